// File: rtl/timer_array.sv
// timer_array: one free-running divider shared by CHANNELS independent TIMA/TMA/TAC-style 8-bit counters.
// Build option: define TIMER_ARRAY_GLITCH_EN for DMG-style spurious increments on DIV/control writes.
module timer_array #(
    parameter int CHANNELS  = 2,
    parameter int DIV_WIDTH = 16,
    parameter int TAP0      = 9,
    parameter int TAP1      = 3,
    parameter int TAP2      = 5,
    parameter int TAP3      = 7,
    parameter int ADDR_W    = $clog2(4*CHANNELS+1)
) (
    input  logic                 clk1,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [7:0]           d_in,
    output logic [7:0]           d_out,
    output logic [CHANNELS-1:0]  irq,
    output logic [DIV_WIDTH-1:0] div_q
);
    localparam int DIV_ADDR = 4*CHANNELS;

    typedef enum logic {ST_COUNT = 1'b0, ST_OVF = 1'b1} ch_state_t;

    ch_state_t           state        [CHANNELS];
    ch_state_t           state_next   [CHANNELS];
    logic [7:0]          counter      [CHANNELS];
    logic [7:0]          counter_next [CHANNELS];
    logic [7:0]          modulo       [CHANNELS];
    logic [7:0]          modulo_next  [CHANNELS];
    logic [2:0]          ctl          [CHANNELS];
    logic [2:0]          ctl_next     [CHANNELS];
    logic [CHANNELS-1:0] cnt_wr, mod_wr, ctl_wr;
    logic [CHANNELS-1:0] sig, inc, prev, prev_next, irq_next;
    logic                div_wr;
    logic [DIV_WIDTH-1:0] div_next;

    function automatic logic tap_bit(input logic [DIV_WIDTH-1:0] div, input logic [1:0] sel);
        logic b;
        case (sel)
            2'd0:    b = div[TAP0];
            2'd1:    b = div[TAP1];
            2'd2:    b = div[TAP2];
            default: b = div[TAP3];
        endcase
        return b;
    endfunction

    always_comb begin
        div_wr    = wr && (int'(addr) == DIV_ADDR);
        div_next  = div_wr ? '0 : div_q + DIV_WIDTH'(1);
        cnt_wr    = '0;
        mod_wr    = '0;
        ctl_wr    = '0;
        sig       = '0;
        inc       = '0;
        prev_next = '0;
        irq_next  = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            counter_next[n] = counter[n];
            modulo_next[n]  = modulo[n];
            ctl_next[n]     = ctl[n];
            state_next[n]   = state[n];

            cnt_wr[n] = wr && (int'(addr) == 4*n);
            mod_wr[n] = wr && (int'(addr) == 4*n + 1);
            ctl_wr[n] = wr && (int'(addr) == 4*n + 2);
            if (mod_wr[n]) modulo_next[n] = d_in;
            if (ctl_wr[n]) ctl_next[n] = d_in[2:0];

`ifdef TIMER_ARRAY_GLITCH_EN
            sig[n]       = ctl[n][2] & tap_bit(div_q, ctl[n][1:0]);
            inc[n]       = prev[n] & ~sig[n];
            prev_next[n] = sig[n];
`else
            // prev follows the raw tap bit; reloading it from the post-write value
            // on DIV/control writes hides the artificial edges those writes create.
            sig[n]       = tap_bit(div_q, ctl[n][1:0]);
            inc[n]       = ctl[n][2] & prev[n] & ~sig[n];
            prev_next[n] = (ctl_wr[n] || div_wr) ? tap_bit(div_next, ctl_next[n][1:0]) : sig[n];
`endif

            case (state[n])
                ST_COUNT: begin
                    if (cnt_wr[n]) begin
                        counter_next[n] = d_in;
                    end else if (inc[n]) begin
                        counter_next[n] = counter[n] + 8'd1;
                        if (counter[n] == 8'hFF) state_next[n] = ST_OVF;
                    end
                end
                ST_OVF: begin
                    state_next[n] = ST_COUNT;
                    if (cnt_wr[n]) begin
                        counter_next[n] = d_in;
                    end else begin
                        counter_next[n] = modulo_next[n];
                        irq_next[n]     = 1'b1;
                    end
                end
                default: state_next[n] = ST_COUNT;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            div_q <= '0;
            prev  <= '0;
            irq   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                state[n]   <= ST_COUNT;
                counter[n] <= '0;
                modulo[n]  <= '0;
                ctl[n]     <= '0;
            end
        end else begin
            div_q <= div_next;
            prev  <= prev_next;
            irq   <= irq_next;
            for (int n = 0; n < CHANNELS; n++) begin
                state[n]   <= state_next[n];
                counter[n] <= counter_next[n];
                modulo[n]  <= modulo_next[n];
                ctl[n]     <= ctl_next[n];
            end
        end
    end

    always_comb begin
        d_out = 8'hFF;
        if (rd) begin
            if (int'(addr) == DIV_ADDR) d_out = div_q[DIV_WIDTH-1 -: 8];
            for (int n = 0; n < CHANNELS; n++) begin
                if (int'(addr) == 4*n)     d_out = counter[n];
                if (int'(addr) == 4*n + 1) d_out = modulo[n];
                if (int'(addr) == 4*n + 2) d_out = {5'b11111, ctl[n]};
            end
        end
    end
endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array with four channels: register-map vector table, directed
// overflow/glitch/reset sequences, then random traffic against a reference model.
module tb_timer_array;
    localparam int CH = 4;
    localparam int AW = 5;

    logic          clk1 = 1'b0;
    logic          reset, wr, rd;
    logic [AW-1:0] addr;
    logic [7:0]    d_in, d_out;
    logic [CH-1:0] irq;
    logic [15:0]   div_q;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    timer_array #(.CHANNELS(CH)) dut (
        .clk1(clk1), .reset(reset), .wr(wr), .rd(rd), .addr(addr),
        .d_in(d_in), .d_out(d_out), .irq(irq), .div_q(div_q)
    );

    always #5 clk1 = ~clk1;

    // Reference model: state as seen during the current cycle.
    int         m_div;
    int         m_cnt [CH];
    int         m_mod [CH];
    int         m_ctl [CH];
    bit         m_ovf [CH];
    bit         m_inc [CH];
`ifdef TIMER_ARRAY_GLITCH_EN
    bit         m_sig [CH];
`endif
    logic [CH-1:0] m_irq;

    function automatic int tap_idx(input int sel);
        case (sel)
            0:       return 9;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit w, input int a, input int d);
        int nd, nmod, nctl, t;
        bit dw, cw, mw, tw;
        if (rst) begin
            m_div = 0;
            m_irq = '0;
            for (int n = 0; n < CH; n++) begin
                m_cnt[n] = 0; m_mod[n] = 0; m_ctl[n] = 0; m_ovf[n] = 0; m_inc[n] = 0;
`ifdef TIMER_ARRAY_GLITCH_EN
                m_sig[n] = 0;
`endif
            end
            return;
        end
        dw = w && (a == 4*CH);
        nd = dw ? 0 : (m_div + 1) % 65536;
        for (int n = 0; n < CH; n++) begin
            cw   = w && (a == 4*n);
            mw   = w && (a == 4*n + 1);
            tw   = w && (a == 4*n + 2);
            nmod = mw ? d : m_mod[n];
            nctl = tw ? (d & 7) : m_ctl[n];
            m_irq[n] = 1'b0;
            if (m_ovf[n]) begin
                m_ovf[n] = 0;
                if (cw) m_cnt[n] = d;
                else begin
                    m_cnt[n] = nmod;
                    m_irq[n] = 1'b1;
                end
            end else if (cw) begin
                m_cnt[n] = d;
            end else if (m_inc[n]) begin
                if (m_cnt[n] == 255) begin
                    m_cnt[n] = 0;
                    m_ovf[n] = 1;
                end else begin
                    m_cnt[n] = m_cnt[n] + 1;
                end
            end
            m_mod[n] = nmod;
            m_ctl[n] = nctl;
            t = tap_idx(nctl & 3);
`ifdef TIMER_ARRAY_GLITCH_EN
            begin
                bit s;
                s = (((nctl >> 2) & 1) == 1) && (((nd >> t) & 1) == 1);
                m_inc[n] = m_sig[n] && !s;
                m_sig[n] = s;
            end
`else
            // a genuine fall of bit t lands the divider on a multiple of 2^(t+1)
            m_inc[n] = (((nctl >> 2) & 1) == 1) && !tw && !dw && ((nd % (1 << (t + 1))) == 0);
`endif
        end
        m_div = nd;
    endtask

    function automatic logic [7:0] model_read(input bit r, input int a);
        if (!r) return 8'hFF;
        if (a == 4*CH) return 8'((m_div >> 8) & 255);
        if (a < 4*CH) begin
            case (a % 4)
                0:       return 8'(m_cnt[a/4]);
                1:       return 8'(m_mod[a/4]);
                2:       return 8'(248 | m_ctl[a/4]);
                default: return 8'hFF;
            endcase
        end
        return 8'hFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input logic [4:0] a, input logic [7:0] d);
        logic [7:0] e;
        wr = w; rd = r; addr = a; d_in = d;
        exp_q.push_back(model_read(r, int'(a)));
        @(negedge clk1);
        e = exp_q.pop_front();
        check("d_out", 32'(d_out), 32'(e));
        check("irq", 32'(irq), 32'(m_irq));
        check("div_q", 32'(div_q), 32'(m_div));
        @(posedge clk1);
        model_edge(reset, w, int'(a), int'(d));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 5'd0, 8'h00);
    endtask

    task automatic peek(input logic [4:0] a, output logic [7:0] v);
        wr = 1'b0; rd = 1'b1; addr = a;
        #1;
        v = d_out;
    endtask

    task automatic wait_zero(input logic [4:0] a, input int budget);
        logic [7:0] v;
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            peek(a, v);
            if (v == 8'h00) ok = 1;
            else cycle(1'b0, 1'b1, a, 8'h00);
        end
        check("wait_ovf", 32'(ok), 32'd1);
    endtask

    task automatic wait_div(input logic [15:0] mask, input logic [15:0] val, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if ((div_q & mask) == val) ok = 1;
            else idle(1);
        end
        check("wait_div", 32'(ok), 32'd1);
    endtask

    task automatic wait_irq(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (irq != '0) ok = 1;
            else idle(1);
        end
        check("wait_irq", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit         w;
        bit         r;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] exp_glitch;
        logic [4:0] ra;
        logic [7:0] rdat;
        int         r;

        vecs[0]  = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  8'h00, 8'hFF};
        vecs[2]  = '{1'b1, 1'b0, 5'd1,  8'h5A, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 5'd1,  8'h00, 8'h5A};
        vecs[4]  = '{1'b1, 1'b0, 5'd2,  8'h03, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 5'd2,  8'h00, 8'hFB};
        vecs[6]  = '{1'b0, 1'b1, 5'd3,  8'h00, 8'hFF};
        vecs[7]  = '{1'b1, 1'b0, 5'd4,  8'h77, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 5'd4,  8'h00, 8'h77};
        vecs[9]  = '{1'b1, 1'b0, 5'd17, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 5'd17, 8'h00, 8'hFF};
        vecs[11] = '{1'b0, 1'b1, 5'd19, 8'h00, 8'hFF};
        vecs[12] = '{1'b0, 1'b1, 5'd14, 8'h00, 8'hF8};
        vecs[13] = '{1'b0, 1'b1, 5'd16, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 1'b1, 5'd15, 8'hAB, 8'hFF};
        vecs[15] = '{1'b0, 1'b1, 5'd15, 8'h00, 8'hFF};
        vecs[16] = '{1'b0, 1'b1, 5'd1,  8'h00, 8'h5A};

        // clock/reset
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; d_in = '0;
        repeat (2) begin
            @(posedge clk1);
            model_edge(1'b1, 1'b0, 0, 0);
        end
        #1;
        reset = 1'b0;
        check("rst_div", 32'(div_q), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_dout_idle", 32'(d_out), 32'hFF);
        peek(5'd0, v);  check("rst_cnt0", 32'(v), 32'h00);
        peek(5'd2, v);  check("rst_ctl0", 32'(v), 32'hF8);

        // register map vectors
        for (int i = 0; i < 17; i++) begin
            wr = vecs[i].w; rd = vecs[i].r; addr = vecs[i].a; d_in = vecs[i].d;
            #1;
            if (vecs[i].r) check($sformatf("vec%0d", i), 32'(d_out), 32'(vecs[i].exp));
            cycle(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
        end

        // increment latency: first count on the 17th edge after the DIV clear
        cycle(1'b1, 1'b0, 5'd16, 8'h00);
        cycle(1'b1, 1'b0, 5'd2, 8'h05);
        idle(15);
        peek(5'd0, v);  check("lat_e16", 32'(v), 32'h00);
        idle(1);
        peek(5'd0, v);  check("lat_e17", 32'(v), 32'h01);
        idle(15);
        peek(5'd0, v);  check("lat_e32", 32'(v), 32'h01);
        idle(1);
        peek(5'd0, v);  check("lat_e33", 32'(v), 32'h02);

        // plain overflow and reload
        cycle(1'b1, 1'b0, 5'd1, 8'hF0);
        cycle(1'b1, 1'b0, 5'd0, 8'hFF);
        wait_zero(5'd0, 40);
        check("ovf_irq_low", 32'(irq), 32'd0);
        idle(1);
        peek(5'd0, v);  check("ovf_reload", 32'(v), 32'hF0);
        check("ovf_irq", 32'(irq), 32'h1);
        idle(1);
        check("ovf_irq_width", 32'(irq), 32'd0);

        // counter write during OVF cancels reload and irq
        cycle(1'b1, 1'b0, 5'd0, 8'hFF);
        wait_zero(5'd0, 40);
        cycle(1'b1, 1'b0, 5'd0, 8'h42);
        peek(5'd0, v);  check("ovfwr_cnt", 32'(v), 32'h42);
        check("ovfwr_irq", 32'(irq), 32'd0);
        idle(1);
        peek(5'd0, v);  check("ovfwr_cnt2", 32'(v), 32'h42);
        check("ovfwr_irq2", 32'(irq), 32'd0);

        // modulo write during OVF feeds the reload
        cycle(1'b1, 1'b0, 5'd0, 8'hFF);
        wait_zero(5'd0, 40);
        cycle(1'b1, 1'b0, 5'd1, 8'h80);
        peek(5'd0, v);  check("ovfmod_cnt", 32'(v), 32'h80);
        check("ovfmod_irq", 32'(irq), 32'h1);

        // reset in the middle of OVF
        cycle(1'b1, 1'b0, 5'd0, 8'hFF);
        wait_zero(5'd0, 40);
        reset = 1'b1;
        cycle(1'b0, 1'b1, 5'd0, 8'h00);
        reset = 1'b0;
        peek(5'd0, v);  check("rstovf_cnt", 32'(v), 32'h00);
        peek(5'd1, v);  check("rstovf_mod", 32'(v), 32'h00);
        check("rstovf_irq", 32'(irq), 32'd0);
        check("rstovf_div", 32'(div_q), 32'd0);
        idle(1);
        check("rstovf_irq2", 32'(irq), 32'd0);

        // DIV write while the tap bit is high
        cycle(1'b1, 1'b0, 5'd2, 8'h05);
        wait_div(16'h000F, 16'h0004, 20);
        cycle(1'b1, 1'b0, 5'd0, 8'h10);
        idle(3);
        cycle(1'b1, 1'b0, 5'd16, 8'h00);
        peek(5'd0, v);  check("divwr_cnt0", 32'(v), 32'h10);
        idle(1);
`ifdef TIMER_ARRAY_GLITCH_EN
        exp_glitch = 8'h11;
`else
        exp_glitch = 8'h10;
`endif
        peek(5'd0, v);  check("divwr_glitch", 32'(v), 32'(exp_glitch));

        // aligned overflows on ch1 (tap sel 1) and ch3 (tap sel 2)
        cycle(1'b1, 1'b0, 5'd2, 8'h00);
        cycle(1'b1, 1'b0, 5'd16, 8'h00);
        cycle(1'b1, 1'b0, 5'd6, 8'h05);
        cycle(1'b1, 1'b0, 5'd14, 8'h06);
        wait_div(16'hFFFF, 16'd50, 80);
        cycle(1'b1, 1'b0, 5'd4, 8'hFF);
        cycle(1'b1, 1'b0, 5'd12, 8'hFF);
        wait_irq(40);
        check("multi_irq", 32'(irq), 32'b1010);
        peek(5'd4, v);  check("multi_cnt1", 32'(v), 32'h00);
        peek(5'd12, v); check("multi_cnt3", 32'(v), 32'h00);
        idle(1);
        check("multi_irq_width", 32'(irq), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                reset = 1'b1;
                cycle(1'b0, 1'b0, 5'd0, 8'h00);
                reset = 1'b0;
            end else if (r < 12) begin
                ra   = 5'($urandom_range(0, 18));
                rdat = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF8, 8'hFF))
                                                   : 8'($urandom_range(0, 255));
                cycle(1'b1, 1'($urandom_range(0, 1)), ra, rdat);
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 8'h00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
